led_count_sequencer: RTL and testbench

Run/pause/speed controller for the board's LED binary counter. It debounces one active-low push-button, classifies each press as short or long, and runs a small state machine. The state machine issues single-cycle increment and clear commands to the LED counter datapath at one of four selectable rates. It sits between the KEY inputs and the LED counter, replacing that counter's fixed 0.2 s enable.

---
 rtl/led_count_sequencer_if.sv | 19 +
 rtl/led_count_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_led_count_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_count_sequencer_if.sv
// rtl/led_count_sequencer_if.sv - command/status bundle between sequencer and LED counter
interface led_count_sequencer_if;
  logic       ovf_in;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       run;
  logic [1:0] state;
  logic [1:0] speed;

  modport master (
    input  ovf_in,
    output cnt_inc, cnt_clr, run, state, speed
  );

  modport slave (
    output ovf_in,
    input  cnt_inc, cnt_clr, run, state, speed
  );
endinterface

// File: rtl/led_count_sequencer.sv
// rtl/led_count_sequencer.sv - debounced run/pause/speed sequencer for the LED counter
module led_count_sequencer #(
  parameter int EXT_CLOCK_FREQ  = 50000000,
  parameter int TICK_CYCLES     = EXT_CLOCK_FREQ / 5,
  parameter int DEBOUNCE_CYCLES = EXT_CLOCK_FREQ / 100,
  parameter int LONG_CYCLES     = EXT_CLOCK_FREQ / 2,
  parameter bit STOP_ON_WRAP    = 1'b0
) (
  input  logic                         EXTCLK,
  input  logic                         RESET_N,
  input  logic                         KEY_MODE_N,
  led_count_sequencer_if.master        cnt_bus
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [PW:0]   TICK_W = (PW + 1)'(TICK_CYCLES);
  localparam logic [DW-1:0] DEB_W  = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] LONG_W = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  // Button path registers
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          db_level_q, db_level_d;
  logic          db_prev_q, db_prev_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          long_evt_q, long_evt_d;
  logic          short_evt_q, short_evt_d;

  // Sequencer registers
  state_t        state_q, state_d;
  logic [1:0]    speed_q, speed_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_clr_q, cnt_clr_d;

  logic [PW:0]   divisor;
  logic          at_wrap;
  logic          cnt_inc;

  // Synchronize, debounce and classify each press as short or long
  always_comb begin
    sync1_d     = KEY_MODE_N;
    sync2_d     = sync1_q;
    db_level_d  = db_level_q;
    db_cnt_d    = '0;
    db_prev_d   = db_level_q;
    hold_cnt_d  = '0;
    long_evt_d  = 1'b0;
    short_evt_d = 1'b0;

    // Any cycle matching the current level restarts the stability count
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DEB_W - 1'b1) begin
        db_level_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    // Hold count saturates at LONG_CYCLES so long_evt fires once per press
    if (!db_level_q) begin
      hold_cnt_d = hold_cnt_q;
      if (hold_cnt_q != LONG_W) begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        long_evt_d = (hold_cnt_q == LONG_W - 1'b1);
      end
    end

    // Release edge: hold count still carries this press's length here
    short_evt_d = db_level_q && !db_prev_q && (hold_cnt_q != LONG_W);
  end

  // Button path register bank
  always_ff @(posedge EXTCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      db_level_q  <= 1'b1;
      db_prev_q   <= 1'b1;
      db_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      long_evt_q  <= 1'b0;
      short_evt_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_prev_d;
      db_cnt_q    <= db_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_evt_q  <= long_evt_d;
      short_evt_q <= short_evt_d;
    end
  end

  // Next-state, speed, prescaler and command decode
  always_comb begin
    divisor   = TICK_W >> speed_q;
    at_wrap   = ({1'b0, presc_q} == divisor - 1'b1);
    cnt_inc   = (state_q == RUN) && at_wrap;
    state_d   = state_q;
    speed_d   = speed_q;
    presc_d   = presc_q;
    cnt_clr_d = 1'b0;

    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (short_evt_q) begin
          state_d = RUN;
        end else if (long_evt_q) begin
          speed_d = speed_q + 2'd1;
        end
      end
      RUN: begin
        presc_d = at_wrap ? '0 : presc_q + 1'b1;
        // Overflow wins; a coincident button event is dropped
        if (STOP_ON_WRAP && cnt_bus.ovf_in) begin
          state_d = DONE;
          presc_d = '0;
        end else if (short_evt_q) begin
          state_d = PAUSE;
        end else if (long_evt_q) begin
          speed_d = speed_q + 2'd1;
          presc_d = '0;
        end
      end
      PAUSE: begin
        if (short_evt_q) begin
          state_d = RUN;
        end else if (long_evt_q) begin
          state_d   = IDLE;
          speed_d   = 2'd0;
          presc_d   = '0;
          cnt_clr_d = 1'b1;
        end
      end
      DONE: begin
        presc_d = '0;
        if (short_evt_q) begin
          state_d   = IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge EXTCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      speed_q   <= 2'd0;
      presc_q   <= '0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      speed_q   <= speed_d;
      presc_q   <= presc_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign cnt_bus.cnt_inc = cnt_inc;
  assign cnt_bus.cnt_clr = cnt_clr_q;
  assign cnt_bus.run     = (state_q == RUN);
  assign cnt_bus.state   = state_q;
  assign cnt_bus.speed   = speed_q;

endmodule

// File: tb/tb_led_count_sequencer.sv
// tb/tb_led_count_sequencer.sv - self-checking bench for led_count_sequencer
module tb_led_count_sequencer;

  localparam int TICK = 16;
  localparam int DEB  = 4;
  localparam int LONG = 32;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic key_n;
  logic ovf;

  led_count_sequencer_if bus ();
  assign bus.ovf_in = ovf;

  led_count_sequencer #(
    .EXT_CLOCK_FREQ (50000000),
    .TICK_CYCLES    (TICK),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .STOP_ON_WRAP   (1'b1)
  ) dut (
    .EXTCLK    (clk),
    .RESET_N   (rst_n),
    .KEY_MODE_N(key_n),
    .cnt_bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: state, speed, RUN cycles since last prescaler clear
  int m_state, m_speed, m_acc;
  bit m_clr;
  int edge_n = 0;
  int ev_edge = -1;
  int ev_type = 0;
  bit ovf_at_evt = 1'b0;
  int inc_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
  endtask

  function automatic int div_of(input int sp);
    return TICK >> sp;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    m_speed = 0;
    m_acc   = 0;
    m_clr   = 1'b0;
    ev_edge = -1;
  endtask

  task automatic model_edge(input bit ovf_seen);
    int evt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    evt = 0;
    if (edge_n == ev_edge) begin
      evt     = ev_type;
      ev_edge = -1;
    end
    if (m_state == S_RUN) m_acc++;
    m_clr = 1'b0;
    case (m_state)
      S_IDLE: begin
        m_acc = 0;
        if (evt == 1) m_state = S_RUN;
        else if (evt == 2) m_speed = (m_speed + 1) % 4;
      end
      S_RUN: begin
        if (ovf_seen) begin
          m_state = S_DONE;
          m_acc   = 0;
        end else if (evt == 1) begin
          m_state = S_PAUSE;
        end else if (evt == 2) begin
          m_speed = (m_speed + 1) % 4;
          m_acc   = 0;
        end
      end
      S_PAUSE: begin
        if (evt == 1) m_state = S_RUN;
        else if (evt == 2) begin
          m_state = S_IDLE;
          m_speed = 0;
          m_acc   = 0;
          m_clr   = 1'b1;
        end
      end
      default: begin
        m_acc = 0;
        if (evt == 1) begin
          m_state = S_IDLE;
          m_clr   = 1'b1;
        end
      end
    endcase
  endtask

  // One clock: advance model on the rising edge, compare on the falling edge
  task automatic tick();
    bit ovf_seen;
    bit exp_inc;
    @(posedge clk);
    edge_n++;
    ovf_seen = ovf;
    model_edge(ovf_seen);
    @(negedge clk);
    exp_inc = (m_state == S_RUN) && (((m_acc + 1) % div_of(m_speed)) == 0);
    chk("state",   {30'b0, bus.state}, m_state);
    chk("speed",   {30'b0, bus.speed}, m_speed);
    chk("run",     {31'b0, bus.run}, (m_state == S_RUN));
    chk("cnt_inc", {31'b0, bus.cnt_inc}, exp_inc);
    chk("cnt_clr", {31'b0, bus.cnt_clr}, m_clr);
    if (bus.cnt_inc === 1'b1) inc_seen++;
    ovf = 1'b0;
    if (ovf_at_evt && (edge_n + 1 == ev_edge)) ovf = 1'b1;
  endtask

  // Clean press of len cycles followed by gap idle cycles
  task automatic press(input int len, input int gap);
    int a;
    key_n = 1'b0;
    a = edge_n + 1;
    if (len >= LONG + 5) begin
      ev_edge = a + DEB + 2 + LONG;
      ev_type = 2;
    end else if (len > DEB) begin
      ev_edge = a + len + DEB + 3;
      ev_type = 1;
    end
    repeat (len) tick();
    key_n = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic short_press();
    press($urandom_range(8, 25), $urandom_range(12, 30));
  endtask

  task automatic long_press();
    press($urandom_range(40, 60), $urandom_range(12, 30));
  endtask

  task automatic pulse_ovf(input int gap);
    ovf = 1'b1;
    tick();
    repeat (gap) tick();
  endtask

  task automatic apply_reset(input int cycles);
    rst_n = 1'b0;
    #1;
    chk("rst_state",   {30'b0, bus.state}, 0);
    chk("rst_speed",   {30'b0, bus.speed}, 0);
    chk("rst_run",     {31'b0, bus.run}, 0);
    chk("rst_cnt_inc", {31'b0, bus.cnt_inc}, 0);
    chk("rst_cnt_clr", {31'b0, bus.cnt_clr}, 0);
    model_reset();
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    key_n = 1'b1;
    ovf   = 1'b0;
    model_reset();
    #2;
    apply_reset(3);

    // Idle after reset, ovf outside RUN ignored
    repeat (100) tick();
    pulse_ovf(5);

    // Glitch shorter than the debounce window
    press(3, 20);

    // Start and steady cadence at speed 0
    press(12, 20);
    inc_seen = 0;
    repeat (64) tick();
    chk("inc_in_64", inc_seen, 4);

    // Four long presses in RUN walk speed 1,2,3 and wrap to 0
    repeat (4) begin
      long_press();
      repeat (20) tick();
    end

    // Pause, resume, then long press in PAUSE clears and returns to IDLE
    repeat (7) tick();
    short_press();
    inc_seen = 0;
    repeat (200) tick();
    chk("inc_in_pause", inc_seen, 0);
    short_press();
    repeat (40) tick();
    short_press();
    long_press();

    // Overflow in RUN stops; short in DONE clears
    short_press();
    repeat (10) tick();
    pulse_ovf(30);
    short_press();

    // Overflow coincident with the pausing short press
    short_press();
    repeat (9) tick();
    ovf_at_evt = 1'b1;
    short_press();
    ovf_at_evt = 1'b0;
    long_press();
    short_press();

    // Randomized mix of presses and overflow pulses
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0: short_press();
        1: long_press();
        2: pulse_ovf($urandom_range(3, 30));
        default: begin
          ovf_at_evt = 1'b1;
          short_press();
          ovf_at_evt = 1'b0;
        end
      endcase
    end

    // Reset while running with the button held; release gives no event
    if (m_state != S_IDLE) short_press();
    if (m_state != S_RUN) short_press();
    repeat (5) tick();
    key_n = 1'b0;
    ev_edge = edge_n + 1 + DEB + 2 + LONG;
    ev_type = 2;
    repeat (10) tick();
    apply_reset(3);
    tick();
    key_n = 1'b1;
    repeat (100) tick();
    chk("post_reset_state", {30'b0, bus.state}, S_IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
